// File: rtl/lcd_ctrl.sv
// lcd_ctrl: FIFO-fed HD44780 write controller with setup/pulse/hold/exec timing, 8- or 4-bit bus.
// Define LCD_INIT_EN to issue the power-up command sequence before serving the FIFO.
module lcd_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int BUS_4BIT    = 0,
    parameter int T_SETUP     = 2,
    parameter int T_PW        = 12,
    parameter int T_HOLD      = 1,
    parameter int T_EXEC      = 1850,
    parameter int T_EXEC_LONG = 76000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] data,
    input  logic        en,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        rw,
    output logic        rs,
    output logic        enable,
    output logic [7:0]  display
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE, HOLD, WAIT} state_t;

    state_t state, state_next;
    logic [8:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [CNT_W-1:0] cnt, cnt_ld;
    logic [8:0] cur;
    logic [7:0] init_byte;
    logic nib, valid_op, push, pop, src_valid, last_half, long_wait;
    logic init_active, cur_init, unused;

    assign unused    = ^data[31:8];
    assign valid_op  = en && (instruction == 32'h0 || instruction == 32'h1);
    assign ready     = count != (AW+1)'(FIFO_DEPTH);
    assign push      = valid_op && ready;
    assign src_valid = init_active || count != '0;
    assign pop       = state == IDLE && count != '0 && !init_active;
    assign last_half = BUS_4BIT == 0 || nib;
    assign long_wait = !cur[8] && cur[7:0] inside {8'h01, 8'h02, 8'h03};
    assign busy      = src_valid || state != IDLE;
    assign rw        = 1'b0;

`ifdef LCD_INIT_EN
    localparam logic [2:0] INIT_LEN = (BUS_4BIT != 0) ? 3'd6 : 3'd4;
    logic [2:0] init_idx, init_k;

    assign init_active = init_idx != INIT_LEN;
    assign init_k      = (BUS_4BIT != 0) ? init_idx : init_idx + 3'd2;

    // 8-bit mode starts with the function-set 0x38 and then shares the common tail
    always_comb
        init_byte = (BUS_4BIT == 0 && init_idx == 3'd0) ? 8'h38 :
                    init_k == 3'd0 ? 8'h33 : init_k == 3'd1 ? 8'h32 :
                    init_k == 3'd2 ? 8'h28 : init_k == 3'd3 ? 8'h0C :
                    init_k == 3'd4 ? 8'h06 : 8'h01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_idx <= '0;
            cur_init <= 1'b0;
        end else if (state == IDLE && src_valid) begin
            cur_init <= init_active;
            if (init_active) init_idx <= init_idx + 3'd1;
        end
    end
`else
    assign init_active = 1'b0;
    assign cur_init    = 1'b0;
    assign init_byte   = '0;
`endif

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {instruction[0], data[7:0]};

    // Occupancy is registered only, so a same-cycle pop never frees a slot for a push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (valid_op && !ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (src_valid) state_next = LOAD;
            LOAD:    state_next = SETUP;
            SETUP:   if (cnt == '0) state_next = PULSE;
            PULSE:   if (cnt == '0) state_next = HOLD;
            HOLD:    if (cnt == '0) state_next = last_half ? WAIT : SETUP;
            WAIT:    if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enable = state == PULSE;
        done   = state == WAIT && cnt == '0 && !cur_init;
    end

    always_comb
        cnt_ld = state_next == SETUP ? CNT_W'(T_SETUP - 1) :
                 state_next == PULSE ? CNT_W'(T_PW - 1) :
                 state_next == HOLD  ? CNT_W'(T_HOLD - 1) :
                 state_next == WAIT  ? (long_wait ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1)) :
                 '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            cur     <= '0;
            nib     <= 1'b0;
            rs      <= 1'b0;
            display <= '0;
        end else begin
            cnt <= state_next != state ? cnt_ld : cnt != '0 ? cnt - 1'b1 : cnt;
            if (state == IDLE && src_valid) begin
                cur <= init_active ? {1'b0, init_byte} : mem[rd_ptr];
                nib <= 1'b0;
            end
            if (state == LOAD) begin
                rs      <= cur[8];
                display <= BUS_4BIT != 0 ? {cur[7:4], 4'h0} : cur[7:0];
            end
            if (state == HOLD && cnt == '0 && !last_half) begin
                display <= {cur[3:0], 4'h0};
                nib     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench for an 8-bit and a 4-bit lcd_ctrl; each enable pulse pops one
// expected {rs, bus} entry, and each done is checked against the exec wait of the last byte.
module tb_lcd_ctrl;
    localparam int TS = 2, TP = 3, TH = 1, TE = 10, TL = 40, FD = 4;
`ifdef LCD_INIT_EN
    localparam bit INIT = 1'b1;
`else
    localparam bit INIT = 1'b0;
`endif

    typedef struct packed {logic rs; logic [7:0] bus; logic lng;} exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] ins_i [2];
    logic [31:0] dat_i [2];
    logic [1:0] en_i = '0;
    logic [1:0] ready_o, busy_o, done_o, ovf_o, rw_o, rs_o, enable_o;
    logic [7:0] disp_o [2];

    exp_t q8[$], q4[$];
    exp_t cur_e [2];
    int vecs = 0, errs = 0, cyc = 0;
    int width [2] = '{0, 0};
    int fall_cyc [2] = '{0, 0};
    int dones [2] = '{0, 0};
    int expd [2] = '{0, 0};
    bit hi [2] = '{0, 0};
    logic [31:0] cmd_ins [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    logic [7:0] cmd_b [6] = '{8'h01, 8'h0C, 8'h02, 8'h03, 8'h04, 8'h01};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_ctrl #(.FIFO_DEPTH(FD), .BUS_4BIT(0), .T_SETUP(TS), .T_PW(TP), .T_HOLD(TH),
               .T_EXEC(TE), .T_EXEC_LONG(TL)) u8 (
        .clk(clk), .rst(rst), .instruction(ins_i[0]), .data(dat_i[0]), .en(en_i[0]),
        .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]), .overflow(ovf_o[0]),
        .rw(rw_o[0]), .rs(rs_o[0]), .enable(enable_o[0]), .display(disp_o[0]));

    lcd_ctrl #(.FIFO_DEPTH(FD), .BUS_4BIT(1), .T_SETUP(TS), .T_PW(TP), .T_HOLD(TH),
               .T_EXEC(TE), .T_EXEC_LONG(TL)) u4 (
        .clk(clk), .rst(rst), .instruction(ins_i[1]), .data(dat_i[1]), .en(en_i[1]),
        .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]), .overflow(ovf_o[1]),
        .rw(rw_o[1]), .rs(rs_o[1]), .enable(enable_o[1]), .display(disp_o[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_byte(input int d, input logic r, input logic [7:0] b);
        logic lng;
        lng = !r && b >= 8'h01 && b <= 8'h03;
        if (d == 0) q8.push_back({r, b, lng});
        else begin
            q4.push_back({r, b[7:4], 4'h0, lng});
            q4.push_back({r, b[3:0], 4'h0, lng});
        end
    endtask

    task automatic push_init();
        if (INIT) begin
            exp_byte(0, 1'b0, 8'h38);
            exp_byte(1, 1'b0, 8'h33);
            exp_byte(1, 1'b0, 8'h32);
            exp_byte(1, 1'b0, 8'h28);
            for (int d = 0; d < 2; d++) begin
                exp_byte(d, 1'b0, 8'h0C);
                exp_byte(d, 1'b0, 8'h06);
                exp_byte(d, 1'b0, 8'h01);
            end
        end
    endtask

    task automatic put(input int d, input logic [31:0] ins, input logic [7:0] b, input bit ok);
        @(negedge clk);
        ins_i[d] = ins;
        dat_i[d] = {24'h0, b};
        en_i[d] = 1'b1;
        if (ok) begin
            exp_byte(d, ins[0], b);
            expd[d]++;
        end
        @(negedge clk);
        en_i[d] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o != 2'b00 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy_o != 2'b00) begin
            vecs++;
            errs++;
            $display("FAIL %s_idle: busy=%b after %0d cycles", tag, busy_o, n);
        end
        check({tag, "_done8"}, dones[0], expd[0]);
        check({tag, "_done4"}, dones[1], expd[1]);
        check({tag, "_q8_left"}, q8.size(), 0);
        check({tag, "_q4_left"}, q4.size(), 0);
    endtask

    task automatic wait_enable(input string tag);
        int n = 0;
        while (!enable_o[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_enable_seen"}, enable_o[0], 1);
    endtask

    // Monitor: pops on each enable rise, checks pulse width, bus hold and done timing
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) hi[i] = 1'b0;
            else begin
                if (enable_o[i] && !hi[i]) begin
                    hi[i] = 1'b1;
                    width[i] = 1;
                    if ((i == 0 ? q8.size() : q4.size()) == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL pulse%0d: unexpected pulse bus=%0h rs=%0b", i, disp_o[i], rs_o[i]);
                    end else begin
                        if (i == 0) cur_e[i] = q8.pop_front();
                        else cur_e[i] = q4.pop_front();
                        check("pulse_rs", rs_o[i], cur_e[i].rs);
                        check("pulse_bus", disp_o[i], cur_e[i].bus);
                    end
                end else if (enable_o[i]) width[i]++;
                else if (hi[i]) begin
                    hi[i] = 1'b0;
                    check("pulse_width", width[i], TP);
                    check("hold_bus", {rs_o[i], disp_o[i]}, {cur_e[i].rs, cur_e[i].bus});
                    fall_cyc[i] = cyc;
                end
                if (done_o[i]) begin
                    dones[i]++;
                    check("done_gap", cyc - fall_cyc[i], TH + (cur_e[i].lng ? TL : TE) - 1);
                    check("busy_at_done", busy_o[i], 1);
                end
            end
        end
    end

    initial begin
        int k;
        ins_i = '{32'h0, 32'h0};
        dat_i = '{32'h0, 32'h0};
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", ready_o[d], 1);
            check("rst_busy", busy_o[d], INIT);
            check("rst_enable", enable_o[d], 0);
            check("rst_display", disp_o[d], 8'h00);
            check("rst_rs", rs_o[d], 0);
            check("rst_done", done_o[d], 0);
            check("rst_overflow", ovf_o[d], 0);
            check("rst_rw", rw_o[d], 0);
        end
        rst = 1'b0;
        push_init();
        wait_idle("init");

        put(0, 32'h5, 8'h41, 1'b0);
        put(0, 32'h100, 8'h42, 1'b0);
        put(0, 32'hFFFFFFFF, 8'h43, 1'b0);
        repeat (3) @(negedge clk);
        check("inv_busy", busy_o[0], 0);
        check("inv_overflow", ovf_o[0], 0);
        check("inv_ready", ready_o[0], 1);

        put(0, 32'h1, 8'h41, 1'b1);
        k = cyc;
        repeat (2) @(negedge clk);
        check("bus_at_k2", {rs_o[0], disp_o[0]}, {1'b1, 8'h41});
        wait_enable("d41");
        check("enable_latency", cyc - k, 2 + TS);
        wait_idle("d41");

        for (int i = 0; i < 6; i++) begin
            put(0, cmd_ins[i], cmd_b[i], 1'b1);
            wait_idle("cmd");
        end

        put(1, 32'h1, 8'hA5, 1'b1);
        put(1, 32'h0, 8'h01, 1'b1);
        wait_idle("nib");

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) check("ovf_ready_3q", ready_o[0], 1);
            if (i == 5) check("ovf_ready_full", ready_o[0], 0);
            ins_i[0] = 32'h1;
            dat_i[0] = 32'h10 + i;
            en_i[0] = 1'b1;
            if (i < 5) begin
                exp_byte(0, 1'b1, 8'(8'h10 + i));
                expd[0]++;
            end
        end
        @(negedge clk);
        en_i[0] = 1'b0;
        check("ovf_set", ovf_o[0], 1);
        wait_idle("ovf");
        check("ovf_sticky", ovf_o[0], 1);

        put(0, 32'h1, 8'h77, 1'b0);
        exp_byte(0, 1'b1, 8'h77);
        wait_enable("abort");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_enable", enable_o[0], 0);
        check("abort_display", disp_o[0], 8'h00);
        check("abort_rs", rs_o[0], 0);
        check("abort_ready", ready_o[0], 1);
        check("abort_busy", busy_o[0], INIT);
        check("abort_overflow", ovf_o[0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_init();
        wait_idle("rst");

        put(0, 32'h1, 8'h5A, 1'b1);
        wait_idle("post");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
